// File: rtl/seq_detect_param.sv
`timescale 1ns/1ps
// seq_detect_param: runtime-configurable Moore serial sequence detector.
//
// Serial bits on `in` are accepted when in_valid is high. A pattern of up to
// MAX_LEN bits and its length are latched by cfg_load. Detection can overlap
// or not, selected per accepted bit by overlap_en. Reset defaults give the
// classic overlapping 1101 detector.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   in           serial data bit
//   in_valid     qualifies `in`
//   overlap_en   1 = overlapping detection, 0 = non-overlapping
//   cfg_load     latch cfg_pattern/cfg_len and flush history (bit on this edge is dropped)
//   cfg_pattern  pattern; bit [len-1] arrives first, bit [0] last
//   cfg_len      pattern length; 0 disables detection, > MAX_LEN clamps to MAX_LEN
//   clr_count    synchronous clear of match_count and count_sat
//   out          registered match flag, high the cycle after a matching bit
//   match_count  saturating match counter
//   count_sat    sticky saturation flag
module seq_detect_param #(
  parameter int unsigned          MAX_LEN     = 8,
  parameter int unsigned          LEN_W       = 4,
  parameter int unsigned          CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]   DEFAULT_PAT = 'h0D,
  parameter int unsigned          DEFAULT_LEN = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in,
  input  logic               in_valid,
  input  logic               overlap_en,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               clr_count,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  // Only MAX_LEN-1 past bits are stored: together with the incoming bit they
  // form the full MAX_LEN-bit comparison window.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               hit;
  logic               match;

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  always_comb begin
    window   = {hist_q, in};
    fill_inc = (fill_q == MaxLenW) ? fill_q : fill_q + 1'b1;
    // fill_inc counts the bit being offered, so the check covers this edge.
    hit      = (len_q != '0) && (fill_inc >= len_q) &&
               ((window & len_mask) == (pat_q & len_mask));
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    match  = 1'b0;

    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = (cfg_len > MaxLenW) ? MaxLenW : cfg_len;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = window[MAX_LEN-2:0];
      fill_d = fill_inc;
      if (hit) begin
        match = 1'b1;
        if (!overlap_en) begin
          fill_d = '0;
        end
      end
    end

    out_d = match;

    if (clr_count) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (match) begin
      if (cnt_q == CntMax) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntMax - 1'b1) begin
          sat_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEFAULT_PAT;
      len_q  <= LEN_W'(DEFAULT_LEN);
      out_q  <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;

endmodule
